// File: rtl/ddc_seq_ctrl.sv
// Mode-driven sequencer for the DDC chain: filters fpga_mod, drains the chain,
// reprograms NCO/FIR over AXI-S config, waits for FIR refill and owns the decimation strobe.
module ddc_seq_ctrl #(
    parameter int unsigned STABLE_CYC = 8,
    parameter int unsigned DRAIN_CYC  = 64,
    parameter int unsigned SETTLE_CYC = 128,
    parameter int unsigned TO_CYC     = 1024,
    parameter logic [31:0] NCO_PINC   = 32'h4000_0000
) (
    input  logic        clk_ddc,
    input  logic        reset,
    input  logic [7:0]  fpga_mod,
    input  logic        fir_dv,
    input  logic        fir_cfg_tready,
    output logic        nco_cfg_tvalid,
    output logic [31:0] nco_cfg_tdata,
    output logic        fir_cfg_tvalid,
    output logic [7:0]  fir_cfg_tdata,
    output logic        ddc_en,
    output logic        ds_valid,
    output logic        busy,
    output logic        cfg_err
);

    localparam int unsigned STAB_W   = $clog2(STABLE_CYC + 1);
    localparam int unsigned DRAIN_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int unsigned SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned TO_W     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_NCO,
        ST_FIR,
        ST_SETTLE
    } state_e;

    state_e state_q, state_d;

    logic [7:0]          cur_mode_q, cur_mode_d;
    logic [7:0]          mod_prev_q, mod_prev_d;
    logic [7:0]          req_mode_q, req_mode_d;
    logic                req_q, req_d;
    logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [3:0]          ds_cnt_q, ds_cnt_d;
    logic                ds_valid_q, ds_valid_d;
    logic                cfg_err_q, cfg_err_d;

    logic       drain_done;
    logic       settle_done;
    logic       to_done;
    logic       fir_exit;
    logic       consume;
    logic       fir_set;
    logic [3:0] ds_max;

    assign drain_done  = (drain_cnt_q == DRAIN_W'(DRAIN_CYC - 1));
    assign settle_done = (settle_cnt_q == SETTLE_W'(SETTLE_CYC - 1));
    assign to_done     = (to_cnt_q == TO_W'(TO_CYC - 1));
    assign fir_exit    = fir_cfg_tready || to_done;
    // A pending request is held off in FIR until the config handshake or timeout.
    assign consume     = req_q && ((state_q != ST_FIR) || fir_exit);
    assign fir_set     = cur_mode_q inside {8'h02, 8'h03, 8'h04};
    assign ds_max      = (cur_mode_q inside {8'h09, 8'h0B, 8'h0C}) ? 4'd9 : 4'd3;

    always_ff @(posedge clk_ddc) begin
        if (reset) begin
            state_q <= ST_DRAIN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (req_q) state_d = ST_DRAIN;
            ST_DRAIN:  if (!req_q && drain_done) state_d = ST_NCO;
            ST_NCO:    state_d = req_q ? ST_DRAIN : ST_FIR;
            ST_FIR:    if (fir_exit) state_d = req_q ? ST_DRAIN : ST_SETTLE;
            ST_SETTLE: begin
                if (req_q) begin
                    state_d = ST_DRAIN;
                end else if (fir_dv && settle_done) begin
                    state_d = ST_RUN;
                end
            end
            default:   state_d = ST_DRAIN;
        endcase
    end

    always_comb begin
        nco_cfg_tvalid = 1'b0;
        nco_cfg_tdata  = '0;
        fir_cfg_tvalid = 1'b0;
        fir_cfg_tdata  = '0;
        ddc_en         = 1'b0;
        busy           = 1'b1;
        unique case (state_q)
            ST_RUN: begin
                ddc_en = 1'b1;
                busy   = 1'b0;
            end
            ST_NCO: begin
                nco_cfg_tvalid = 1'b1;
                nco_cfg_tdata  = NCO_PINC;
            end
            ST_FIR: begin
                fir_cfg_tvalid = 1'b1;
                fir_cfg_tdata  = {7'd0, fir_set};
            end
            ST_SETTLE: ddc_en = 1'b1;
            default: ;
        endcase
    end

    assign ds_valid = ds_valid_q;
    assign cfg_err  = cfg_err_q;

    always_comb begin
        mod_prev_d = fpga_mod;
        // Counter holds the number of consecutive cycles fpga_mod has kept its value.
        if (fpga_mod != mod_prev_q) begin
            stab_cnt_d = STAB_W'(1);
        end else if (stab_cnt_q == STAB_W'(STABLE_CYC)) begin
            stab_cnt_d = stab_cnt_q;
        end else begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end

        req_d      = req_q;
        req_mode_d = req_mode_q;
        cur_mode_d = cur_mode_q;
        if ((stab_cnt_d == STAB_W'(STABLE_CYC)) && (fpga_mod != cur_mode_q)) begin
            req_d      = 1'b1;
            req_mode_d = fpga_mod;
        end
        if (consume) begin
            req_d      = 1'b0;
            cur_mode_d = req_mode_q;
        end

        drain_cnt_d = '0;
        if ((state_q == ST_DRAIN) && !req_q && !drain_done) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
        end

        to_cnt_d = '0;
        if ((state_q == ST_FIR) && !fir_exit) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        settle_cnt_d = '0;
        if ((state_q == ST_SETTLE) && !req_q) begin
            if (!fir_dv) begin
                settle_cnt_d = settle_cnt_q;
            end else if (!settle_done) begin
                settle_cnt_d = settle_cnt_q + 1'b1;
            end
        end

        cfg_err_d = cfg_err_q || ((state_q == ST_FIR) && !fir_cfg_tready && to_done);

        ds_cnt_d   = '0;
        ds_valid_d = 1'b0;
        if ((state_q == ST_RUN) && !req_q) begin
            ds_valid_d = fir_dv && (ds_cnt_q == 4'd0);
            if (!fir_dv) begin
                ds_cnt_d = ds_cnt_q;
            end else if (ds_cnt_q != ds_max) begin
                ds_cnt_d = ds_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_ddc) begin
        if (reset) begin
            cur_mode_q   <= fpga_mod;
            mod_prev_q   <= fpga_mod;
            req_mode_q   <= '0;
            req_q        <= 1'b0;
            stab_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            settle_cnt_q <= '0;
            to_cnt_q     <= '0;
            ds_cnt_q     <= '0;
            ds_valid_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            cur_mode_q   <= cur_mode_d;
            mod_prev_q   <= mod_prev_d;
            req_mode_q   <= req_mode_d;
            req_q        <= req_d;
            stab_cnt_q   <= stab_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            to_cnt_q     <= to_cnt_d;
            ds_cnt_q     <= ds_cnt_d;
            ds_valid_q   <= ds_valid_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_ddc_seq_ctrl.sv
// Directed bench for ddc_seq_ctrl: power-up sequence, mode changes, glitch rejection,
// FIR config back-pressure and timeout, reset mid-sequence, decimation strobe pattern.
module tb_ddc_seq_ctrl;

    logic        clk_ddc = 1'b0;
    logic        reset;
    logic [7:0]  fpga_mod;
    logic        fir_dv;
    logic        fir_cfg_tready;
    logic        nco_cfg_tvalid;
    logic [31:0] nco_cfg_tdata;
    logic        fir_cfg_tvalid;
    logic [7:0]  fir_cfg_tdata;
    logic        ddc_en;
    logic        ds_valid;
    logic        busy;
    logic        cfg_err;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [45:0] out_vec;
    assign out_vec = {nco_cfg_tvalid, nco_cfg_tdata, fir_cfg_tvalid, fir_cfg_tdata,
                      ddc_en, ds_valid, busy, cfg_err};

    // Only busy is high while held in reset.
    localparam logic [45:0] RST_OUT = 46'h2;

    ddc_seq_ctrl #(
        .STABLE_CYC(8),
        .DRAIN_CYC (64),
        .SETTLE_CYC(128),
        .TO_CYC    (1024),
        .NCO_PINC  (32'h4000_0000)
    ) dut (
        .clk_ddc       (clk_ddc),
        .reset         (reset),
        .fpga_mod      (fpga_mod),
        .fir_dv        (fir_dv),
        .fir_cfg_tready(fir_cfg_tready),
        .nco_cfg_tvalid(nco_cfg_tvalid),
        .nco_cfg_tdata (nco_cfg_tdata),
        .fir_cfg_tvalid(fir_cfg_tvalid),
        .fir_cfg_tdata (fir_cfg_tdata),
        .ddc_en        (ddc_en),
        .ds_valid      (ds_valid),
        .busy          (busy),
        .cfg_err       (cfg_err)
    );

    always #5 clk_ddc = ~clk_ddc;

    task automatic step();
        @(posedge clk_ddc);
        @(negedge clk_ddc);
    endtask

    task automatic wait_nco(input int unsigned bound, output int unsigned n);
        n = 0;
        while (!nco_cfg_tvalid && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic test_settle();
        fir_dv = 1'b1;
        repeat (127) step();
        vectors++;
        if ({busy, ddc_en} !== 2'b11) begin
            miscompares++;
            $display("FAIL settle_127: busy,ddc_en=%b expected 11", {busy, ddc_en});
        end
        step();
        vectors++;
        if ({busy, ddc_en, ds_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL settle_128: busy,ddc_en,ds_valid=%b expected 010", {busy, ddc_en, ds_valid});
        end
        fir_dv = 1'b0;
    endtask

    task automatic test_decimation(input int unsigned ds, input int unsigned pulses);
        logic exp_v;
        for (int unsigned k = 0; k < pulses; k++) begin
            fir_dv = 1'b1;
            step();
            exp_v = ((k % ds) == 0);
            vectors++;
            if (ds_valid !== exp_v) begin
                miscompares++;
                $display("FAIL ds_pulse DS=%0d dv#%0d: ds_valid=%b expected %b", ds, k + 1, ds_valid, exp_v);
            end
            fir_dv = 1'b0;
            step();
            vectors++;
            if (ds_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL ds_gap DS=%0d after dv#%0d: ds_valid=%b expected 0", ds, k + 1, ds_valid);
            end
        end
    endtask

    task automatic test_reset();
        int unsigned n;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (out_vec !== RST_OUT) begin
                miscompares++;
                $display("FAIL reset_outputs cyc%0d: got %h expected %h", i, out_vec, RST_OUT);
            end
        end
        reset = 1'b0;
        wait_nco(200, n);
        vectors++;
        if (n !== 64) begin
            miscompares++;
            $display("FAIL powerup_nco_latency: %0d cycles expected 64", n);
        end
        vectors++;
        if (nco_cfg_tdata !== 32'h4000_0000) begin
            miscompares++;
            $display("FAIL nco_tdata: got %h expected 40000000", nco_cfg_tdata);
        end
        step();
        vectors++;
        if ({nco_cfg_tvalid, fir_cfg_tvalid, fir_cfg_tdata} !== {1'b0, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL powerup_fir_cfg: nco_v,fir_v,tdata=%h expected 100", {nco_cfg_tvalid, fir_cfg_tvalid, fir_cfg_tdata});
        end
        step();
        vectors++;
        if ({fir_cfg_tvalid, ddc_en, busy} !== 3'b011) begin
            miscompares++;
            $display("FAIL powerup_settle_entry: fir_v,ddc_en,busy=%b expected 011", {fir_cfg_tvalid, ddc_en, busy});
        end
        test_settle();
        test_decimation(4, 12);
    endtask

    task automatic test_mode_change();
        int unsigned n;
        fpga_mod = 8'h03;
        wait_nco(300, n);
        vectors++;
        if (n !== 73) begin
            miscompares++;
            $display("FAIL mode_nco_latency: %0d cycles expected 73", n);
        end
        vectors++;
        if ({busy, ddc_en} !== 2'b10) begin
            miscompares++;
            $display("FAIL mode_nco_state: busy,ddc_en=%b expected 10", {busy, ddc_en});
        end
        step();
        vectors++;
        if ({fir_cfg_tvalid, fir_cfg_tdata} !== {1'b1, 8'h01}) begin
            miscompares++;
            $display("FAIL mode03_fir_cfg: fir_v,tdata=%h expected 101", {fir_cfg_tvalid, fir_cfg_tdata});
        end
        step();
        test_settle();
        test_decimation(4, 8);
    endtask

    task automatic test_glitch();
        logic seen_bad = 1'b0;
        fpga_mod = 8'h0B;
        repeat (5) begin step(); seen_bad |= busy | nco_cfg_tvalid; end
        fpga_mod = 8'h0C;
        repeat (5) begin step(); seen_bad |= busy | nco_cfg_tvalid; end
        fpga_mod = 8'h03;
        repeat (100) begin step(); seen_bad |= busy | nco_cfg_tvalid; end
        vectors++;
        if (seen_bad !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_no_sequence: busy/nco seen=%b expected 0", seen_bad);
        end
        test_decimation(4, 8);
    endtask

    task automatic test_hold_tready();
        int unsigned n;
        fir_cfg_tready = 1'b0;
        fpga_mod = 8'h0C;
        wait_nco(300, n);
        vectors++;
        if (n !== 73) begin
            miscompares++;
            $display("FAIL mode0c_nco_latency: %0d cycles expected 73", n);
        end
        step();
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({fir_cfg_tvalid, fir_cfg_tdata} !== {1'b1, 8'h00}) begin
                miscompares++;
                $display("FAIL fir_hold cyc%0d: fir_v,tdata=%h expected 100", i, {fir_cfg_tvalid, fir_cfg_tdata});
            end
            if (i == 9) fir_cfg_tready = 1'b1;
            step();
        end
        vectors++;
        if ({fir_cfg_tvalid, ddc_en, cfg_err} !== 3'b010) begin
            miscompares++;
            $display("FAIL fir_handshake_exit: fir_v,ddc_en,cfg_err=%b expected 010", {fir_cfg_tvalid, ddc_en, cfg_err});
        end
        test_settle();
        test_decimation(10, 30);
    endtask

    task automatic test_timeout();
        int unsigned n;
        fir_cfg_tready = 1'b0;
        fpga_mod = 8'h09;
        wait_nco(300, n);
        step();
        n = 0;
        while (fir_cfg_tvalid && n < 2000) begin
            n++;
            step();
        end
        vectors++;
        if (n !== 1024) begin
            miscompares++;
            $display("FAIL timeout_tvalid_len: %0d cycles expected 1024", n);
        end
        vectors++;
        if ({cfg_err, ddc_en, busy} !== 3'b111) begin
            miscompares++;
            $display("FAIL timeout_state: cfg_err,ddc_en,busy=%b expected 111", {cfg_err, ddc_en, busy});
        end
        test_settle();
        vectors++;
        if (cfg_err !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_err_sticky: cfg_err=%b expected 1", cfg_err);
        end
        test_decimation(10, 10);
    endtask

    task automatic test_reset_mid_fir();
        int unsigned n;
        fpga_mod = 8'h02;
        wait_nco(300, n);
        step();
        repeat (5) step();
        vectors++;
        if (fir_cfg_tvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL midfir_pre_reset: fir_v=%b expected 1", fir_cfg_tvalid);
        end
        reset = 1'b1;
        step();
        vectors++;
        if (out_vec !== RST_OUT) begin
            miscompares++;
            $display("FAIL midfir_reset_outputs: got %h expected %h", out_vec, RST_OUT);
        end
        step();
        reset = 1'b0;
        fir_cfg_tready = 1'b1;
        wait_nco(200, n);
        vectors++;
        if (n !== 64) begin
            miscompares++;
            $display("FAIL restart_nco_latency: %0d cycles expected 64", n);
        end
        step();
        vectors++;
        if ({fir_cfg_tvalid, fir_cfg_tdata} !== {1'b1, 8'h01}) begin
            miscompares++;
            $display("FAIL restart_mode02_fir_cfg: fir_v,tdata=%h expected 101", {fir_cfg_tvalid, fir_cfg_tdata});
        end
        step();
        vectors++;
        if ({ddc_en, busy, cfg_err} !== 3'b110) begin
            miscompares++;
            $display("FAIL restart_settle: ddc_en,busy,cfg_err=%b expected 110", {ddc_en, busy, cfg_err});
        end
    endtask

    initial begin
        reset          = 1'b1;
        fpga_mod       = 8'h01;
        fir_dv         = 1'b0;
        fir_cfg_tready = 1'b1;
        test_reset();
        test_mode_change();
        test_glitch();
        test_hold_tready();
        test_timeout();
        test_reset_mid_fir();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
